// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM state
// encoding, line-level constants and parity-type encodings.
package uart_pkg;

  // Frame controller states, one bit time each except DATA
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Parity type encodings on PAR_TYP
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity of the word accepted for transmission.
// The parity type is applied at load time, so the stored bit is already the
// value to put on the line; the type does not need to be kept separately.
// Built only when UART_TX_PARITY_EN is defined.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [DATA_WIDTH:0] xor_chain;
  logic                parity_reg;

  // Seed the chain with 1 for odd parity so the result is ^data ^ par_typ
  assign xor_chain[0] = (par_typ == ODD);

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
      assign xor_chain[gi+1] = xor_chain[gi] ^ data[gi];
    end
  endgenerate

  // Capture the parity of the word at the moment it is accepted
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= xor_chain[DATA_WIDTH];
    end
  end

  assign parity = parity_reg;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: accepts a parallel word, launches the
// serializer and frames the line as start / data / [parity] / stop.
// Optional build macro: UART_TX_PARITY_EN (parity state and parity register).
// Without it PAR_EN and PAR_TYP are ignored and every frame has no parity bit.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t                state_reg;
  logic                  ser_en_reg;
  logic [DATA_WIDTH-1:0] ser_p_data_reg;
  logic                  accept;
  logic                  tx_next;

  // A new word is taken only when idle or in the last bit of a frame
  assign accept = Data_Valid && ((state_reg == IDLE) || (state_reg == STOP));

`ifdef UART_TX_PARITY_EN
  logic par_en_reg;
  logic parity_bit;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (accept),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .parity  (parity_bit)
  );

  // Freeze the parity enable for the frame being sent
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      par_en_reg <= 1'b0;
    end else if (accept) begin
      par_en_reg <= PAR_EN;
    end
  end
`else
  // Parity configuration inputs are kept on the port list but have no effect
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  // Frame sequencer; ser_en is registered so it is high for the START cycle only
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg      <= IDLE;
      ser_en_reg     <= 1'b0;
      ser_p_data_reg <= '0;
    end else begin
      ser_en_reg <= 1'b0;
      if (accept) begin
        ser_p_data_reg <= P_DATA;
      end
      case (state_reg)
        IDLE: begin
          if (Data_Valid) begin
            state_reg  <= START;
            ser_en_reg <= 1'b1;
          end
        end
        START: begin
          state_reg <= DATA;
        end
        DATA: begin
          if (ser_done) begin
`ifdef UART_TX_PARITY_EN
            state_reg <= par_en_reg ? PARITY : STOP;
`else
            state_reg <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_reg <= STOP;
        end
`endif
        STOP: begin
          if (Data_Valid) begin
            state_reg  <= START;
            ser_en_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Line level decoded from the registered state
  always_comb begin
    tx_next = IDLE_LEVEL;
    case (state_reg)
      START:  tx_next = START_BIT;
      DATA:   tx_next = ser_data;
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      STOP:   tx_next = STOP_BIT;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  assign TX_OUT     = tx_next;
  assign Busy       = (state_reg != IDLE);
  assign ser_en     = ser_en_reg;
  assign ser_p_data = ser_p_data_reg;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl with a behavioural serializer.
// Expected per-cycle {TX_OUT, Busy, ser_en} values are queued when a frame is
// launched and popped one per bit time.
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_BUILT = 1'b1;
`else
  localparam logic PAR_BUILT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic [7:0] ser_p_data;
  logic       TX_OUT;
  logic       Busy;

  always #5 Clk = ~Clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .ser_p_data (ser_p_data),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  // Serializer model: bit i (LSB first) in DATA cycle i, done in cycle ser_last
  int         ser_last = 7;
  int         ser_cnt;
  logic       ser_act;
  logic [7:0] ser_sh;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ser_act <= 1'b0;
      ser_cnt <= 0;
      ser_sh  <= 8'h00;
    end else if (ser_en) begin
      ser_act <= 1'b1;
      ser_cnt <= 0;
      ser_sh  <= ser_p_data;
    end else if (ser_act) begin
      if (ser_cnt == ser_last) ser_act <= 1'b0;
      ser_cnt <= ser_cnt + 1;
    end
  end

  assign ser_data = ser_sh[ser_cnt[2:0]];
  assign ser_done = ser_act && (ser_cnt == ser_last);

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic tx;
    logic busy;
    logic sen;
  } exp_t;

  exp_t exp_q[$];

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [3:0] nbits;
    logic       exp_par;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic tx, input logic busy, input logic sen);
    exp_t e;
    e.tx   = tx;
    e.busy = busy;
    e.sen  = sen;
    exp_q.push_back(e);
  endfunction

  function automatic void push_frame(input logic [7:0] d, input int nb, input logic hp, input logic p);
    push_exp(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < nb; k++) push_exp(d[k], 1'b1, 1'b0);
    if (hp) push_exp(p, 1'b1, 1'b0);
    push_exp(1'b1, 1'b1, 1'b0);
  endfunction

  // Walk the expected queue one bit time per entry, starting in the START cycle
  task automatic run(input logic [7:0] first_data, input int dv_low_at, input int pulse_at,
                     input logic [7:0] mid_data, input logic mid_typ);
    int   i;
    exp_t e;
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == dv_low_at) Data_Valid = 1'b0;
      if (i == 1) begin
        P_DATA  = mid_data;
        PAR_TYP = mid_typ;
      end
      if (i == pulse_at) Data_Valid = 1'b1;
      if (pulse_at >= 0 && i == pulse_at + 1) Data_Valid = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("tx_busy_sen[%0d]", i), {29'd0, TX_OUT, Busy, ser_en},
            {29'd0, e.tx, e.busy, e.sen});
      if (i == 0) check("ser_p_data", {24'd0, ser_p_data}, {24'd0, first_data});
      i++;
      @(negedge Clk);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic pe, input logic pt, input int nb);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    ser_last   = nb - 1;
    Data_Valid = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 4'd8, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 4'd8, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 4'd8, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 4'd1, 1'b1};
    vecs[6] = '{8'h6E, 1'b1, 1'b1, 4'd8, 1'b0};

    // Reset state
    #2;
    check("reset_line", {29'd0, TX_OUT, Busy, ser_en}, 32'b100);
    check("reset_ser_p_data", {24'd0, ser_p_data}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("idle_after_reset", {29'd0, TX_OUT, Busy, ser_en}, 32'b100);

    // Table-driven single frames; config is changed mid-frame every time
    for (int v = 0; v < 7; v++) begin
      push_frame(vecs[v].data, int'(vecs[v].nbits), vecs[v].par_en & PAR_BUILT, vecs[v].exp_par);
      push_exp(1'b1, 1'b0, 1'b0);
      launch(vecs[v].data, vecs[v].par_en, vecs[v].par_typ, int'(vecs[v].nbits));
      run(vecs[v].data, 0, -1, ~vecs[v].data, ~vecs[v].par_typ);
    end

    // Back-to-back: Data_Valid held, second word presented during the STOP cycle
    push_frame(8'h55, 8, 1'b0, 1'b0);
    push_frame(8'h0F, 8, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0);
    launch(8'h55, 1'b0, 1'b0, 8);
    run(8'h55, 10, -1, 8'h0F, 1'b0);

    // Data_Valid pulse in the middle of DATA is ignored
    push_frame(8'hC3, 8, PAR_BUILT, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0);
    launch(8'hC3, 1'b1, 1'b0, 8);
    run(8'hC3, 0, 4, 8'h3C, 1'b1);

    // Reset asserted mid-frame takes effect without a clock edge
    launch(8'hA5, 1'b1, 1'b0, 8);
    Data_Valid = 1'b0;
    check("rst_seq_start", {29'd0, TX_OUT, Busy, ser_en}, 32'b011);
    repeat (3) @(negedge Clk);
    check("rst_seq_in_data", {31'd0, Busy}, 32'd1);
    Reset = 1'b0;
    #1;
    check("async_reset_line", {29'd0, TX_OUT, Busy, ser_en}, 32'b100);
    check("async_reset_data", {24'd0, ser_p_data}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("no_resume_after_reset", {29'd0, TX_OUT, Busy, ser_en}, 32'b100);

    push_frame(8'hA5, 8, PAR_BUILT, 1'b1);
    push_exp(1'b1, 1'b0, 1'b0);
    launch(8'hA5, 1'b1, 1'b1, 8);
    run(8'hA5, 0, -1, 8'h5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
